// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 decode, FSM states,
// byte-enable patterns and the latched request descriptor.
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    localparam int NUM_LANES = 4;
    localparam int LANE_W    = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } lsu_size_t;

    // Request fields that must survive past the request cycle for load extraction.
    typedef struct packed {
        logic       we;
        logic [2:0] f3;
        logic [1:0] off;
    } lsu_op_t;

    // Unlisted encodings fall through to a full word.
    function automatic lsu_size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: f3_size = SZ_B;
            F3_LH, F3_LHU: f3_size = SZ_H;
            default:       f3_size = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load lane
// select with sign/zero extension, and misalignment detection.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]                   funct3,
    input  logic [1:0]                   off,
    input  logic [NUM_LANES*LANE_W-1:0]  st_data,
    input  logic [NUM_LANES*LANE_W-1:0]  rdata,
    output logic [NUM_LANES-1:0]         be,
    output logic [NUM_LANES*LANE_W-1:0]  wdata,
    output logic [NUM_LANES*LANE_W-1:0]  ld_ext,
    output logic                         misalign
);

    lsu_size_t sz;
    logic      is_unsigned;
    logic [NUM_LANES-1:0][LANE_W-1:0] rbytes;
    logic [LANE_W-1:0]   byte_sel;
    logic [2*LANE_W-1:0] half_sel;

    assign sz          = f3_size(funct3);
    assign is_unsigned = funct3[2];
    assign rbytes      = rdata;

    always_comb begin
        be       = BE_WORD;
        misalign = 1'b0;
        case (sz)
            SZ_B: begin
                be       = BE_BYTE << off;
                misalign = 1'b0;
            end
            SZ_H: begin
                be       = BE_HALF << {off[1], 1'b0};
                misalign = off[0];
            end
            default: begin
                be       = BE_WORD;
                misalign = |off;
            end
        endcase
    end

    // Narrow stores are replicated so every lane carries the data; be picks the lane.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_wlane
        always_comb begin
            case (sz)
                SZ_B:    wdata[i*LANE_W +: LANE_W] = st_data[LANE_W-1:0];
                SZ_H:    wdata[i*LANE_W +: LANE_W] = st_data[(i%2)*LANE_W +: LANE_W];
                default: wdata[i*LANE_W +: LANE_W] = st_data[i*LANE_W +: LANE_W];
            endcase
        end
    end

    assign byte_sel = rbytes[off];
    assign half_sel = off[1] ? {rbytes[3], rbytes[2]} : {rbytes[1], rbytes[0]};

    always_comb begin
        case (sz)
            SZ_B:    ld_ext = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SZ_H:    ld_ext = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: ld_ext = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_responder.sv
// Load/store unit FSM: issues one req/ack memory access per request and stalls the core.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of truncating them.
module lsu_mem_responder
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_req,
    input  logic              st_req,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] ld_data,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [3:0]        m_be,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
);

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    lsu_state_t        state;
    lsu_op_t           op_q;
    logic [7:0]        cnt;
    logic              req_any;
    logic [2:0]        a_f3;
    logic [1:0]        a_off;
    logic [3:0]        a_be;
    logic [DATA_W-1:0] a_wdata;
    logic [DATA_W-1:0] a_ld;
    logic              a_misalign;

    assign req_any = ld_req | st_req;

    // Core-side request in IDLE, latched descriptor while the access is in flight.
    assign a_f3  = (state == IDLE) ? funct3     : op_q.f3;
    assign a_off = (state == IDLE) ? addr[1:0]  : op_q.off;

    lsu_align u_align (
        .funct3   (a_f3),
        .off      (a_off),
        .st_data  (st_data),
        .rdata    (m_rdata),
        .be       (a_be),
        .wdata    (a_wdata),
        .ld_ext   (a_ld),
        .misalign (a_misalign)
    );

    // Combinational in IDLE so the core freezes in the very cycle it asks.
    assign stall = (state == ACCESS) | ((state == IDLE) & req_any & ~done);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            op_q    <= '0;
            cnt     <= '0;
            ld_data <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_be    <= '0;
            m_wdata <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        op_q <= '{we: st_req, f3: funct3, off: addr[1:0]};
                        cnt  <= '0;
                        if (TRAP_EN && a_misalign) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            err     <= 1'b1;
                            ld_data <= '0;
                        end else begin
                            state   <= ACCESS;
                            m_req   <= 1'b1;
                            m_we    <= st_req;
                            m_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            m_be    <= a_be;
                            m_wdata <= a_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (m_ack) begin
                        state <= DONE;
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                        done  <= 1'b1;
                        if (!op_q.we) ld_data <= a_ld;
                    end else if (cnt == TO_CNT) begin
                        state   <= DONE;
                        m_req   <= 1'b0;
                        m_we    <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        ld_data <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Randomized bench for lsu_mem_responder against an arithmetic reference model.
module tb_lsu_mem_responder;

    localparam int TIMEOUT = 255;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk, rst_n;
    logic        ld_req, st_req;
    logic [2:0]  funct3;
    logic [31:0] addr, st_data, ld_data;
    logic        stall, done, err;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_be;

    int n_chk  = 0;
    int n_pass = 0;

    lsu_mem_responder #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .st_req(st_req),
        .funct3(funct3), .addr(addr), .st_data(st_data), .ld_data(ld_data),
        .stall(stall), .done(done), .err(err), .m_req(m_req), .m_we(m_we),
        .m_addr(m_addr), .m_be(m_be), .m_wdata(m_wdata), .m_ack(m_ack),
        .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int s = size_of(f3);
        if (s == 1) return 4'(1 << a[1:0]);
        if (s == 2) return 4'(3 << (2 * a[1]));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        int s = size_of(f3);
        if (s == 1) return 32'(d[7:0]) * 32'h0101_0101;
        if (s == 2) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_ld(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        int s = size_of(f3);
        if (s == 1) begin
            v = (rd >> (8 * a[1:0])) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (s == 2) begin
            v = (rd >> (16 * a[1])) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
        int s = size_of(f3);
        return (s == 2 && a[0]) || (s == 4 && a[1:0] != 2'b00);
    endfunction

    // delay: number of m_req cycles before ack (0 = ack in first cycle), -1 = never ack.
    task automatic do_access(input string tag, input bit is_ld, input bit is_st,
                             input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             input int delay, input logic [31:0] rd);
        int  nreq = 0;
        int  lat  = 0;
        bit  seen = 0;
        bit  trap = TRAP && is_misaligned(f3, a);
        bit  exp_err = trap || (delay < 0);
        int  exp_nreq = trap ? 0 : (delay < 0 ? TIMEOUT + 1 : delay + 1);
        @(posedge clk); #1;
        ld_req = is_ld; st_req = is_st; funct3 = f3; addr = a; st_data = d;
        #1;
        check({tag, "_stall_req"}, 32'(stall), 32'd1);
        for (int c = 1; c < 400 && !seen; c++) begin
            @(posedge clk); #1;
            m_ack = 1'b0; m_rdata = $urandom;
            if (done) begin
                seen = 1; lat = c;
            end else if (m_req) begin
                if (nreq == 0) begin
                    check({tag, "_m_addr"},  m_addr, a & 32'hFFFF_FFFC);
                    check({tag, "_m_be"},    32'(m_be), 32'(model_be(f3, a)));
                    check({tag, "_m_we"},    32'(m_we), 32'(is_st));
                    if (is_st) check({tag, "_m_wdata"}, m_wdata, model_wdata(f3, d));
                end
                if (nreq == delay) begin
                    m_ack = 1'b1; m_rdata = rd;
                end
                nreq++;
            end else begin
                check({tag, "_progress"}, 32'(m_req), 32'd1);
                seen = 1;
            end
        end
        if (!seen) check({tag, "_done_bound"}, 32'd0, 32'd1);
        check({tag, "_done"},  32'(done), 32'd1);
        check({tag, "_err"},   32'(err), 32'(exp_err));
        check({tag, "_stall_done"}, 32'(stall), 32'd0);
        check({tag, "_nreq"},  32'(nreq), 32'(exp_nreq));
        check({tag, "_lat"},   32'(lat), 32'(exp_nreq + 1));
        if (is_ld && !is_st)
            check({tag, "_ld_data"}, ld_data, exp_err ? 32'd0 : model_ld(f3, a, rd));
        ld_req = 1'b0; st_req = 1'b0;
        @(posedge clk); #1;
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_req"},  32'(m_req), 32'd0);
        check({tag, "_idle_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; ld_req = 1'b0; st_req = 1'b0; funct3 = 3'd0;
        addr = '0; st_data = '0; m_ack = 1'b0; m_rdata = '0;
        #12;
        check("rst_m_req", 32'(m_req), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_ld",    ld_data, 32'd0);
        check("rst_m_be",  32'(m_be), 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        rst_n = 1'b1;

        do_access("sw",  0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 2, 32'd0);
        do_access("lb",  1, 0, 3'b000, 32'h103, 32'd0, 0, 32'h80FF_0000);
        do_access("lbu", 1, 0, 3'b100, 32'h103, 32'd0, 0, 32'h80FF_0000);
        do_access("sh",  0, 1, 3'b001, 32'h102, 32'h1234_ABCD, 1, 32'd0);
        do_access("lw_to", 1, 0, 3'b010, 32'h104, 32'd0, -1, 32'd0);
        do_access("lh_mis", 1, 0, 3'b001, 32'h101, 32'd0, 1, 32'hCAFE_F00D);
        do_access("ldst", 1, 1, 3'b000, 32'h201, 32'h0000_005A, 0, 32'd0);

        // Stray ack outside an access must not produce a completion.
        @(posedge clk); #1; m_ack = 1'b1;
        @(posedge clk); #1; m_ack = 1'b0;
        check("stray_done", 32'(done), 32'd0);
        check("stray_req",  32'(m_req), 32'd0);
        @(posedge clk); #1;
        check("stray_done2", 32'(done), 32'd0);

        // Asynchronous reset while an access is outstanding.
        ld_req = 1'b1; funct3 = 3'b010; addr = 32'h200;
        @(posedge clk); #1;
        check("mid_req", 32'(m_req), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", 32'(m_req), 32'd0);
        ld_req = 1'b0;
        #1;
        check("mid_rst_stall", 32'(stall), 32'd0);
        #2; rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_stall", 32'(stall), 32'd0);
        check("post_rst_done",  32'(done), 32'd0);
        check("post_rst_req",   32'(m_req), 32'd0);
        @(posedge clk); #1;
        check("post_rst_done2", 32'(done), 32'd0);

        for (int i = 0; i < 40; i++) begin
            int          op    = int'($urandom_range(0, 2));
            bit          st    = (op != 0);
            bit          ld    = (op != 1);
            logic [2:0]  f3    = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            do_access($sformatf("rnd%0d", i), ld, st, f3, $urandom, $urandom,
                      int'($urandom_range(0, 4)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
